// File: rtl/difftest_sched_pkg.sv
// Shared types for the difftest commit scheduler: FSM states, the queued record
// layout and a slot-count helper used for compaction.
package difftest_sched_pkg;

   localparam int MAX_SLOTS = 4;
   localparam int REC_XLEN  = 64;
   localparam int REC_INST  = 32;

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE, ST_ERR} sched_state_e;

   // Records carry the widest supported fields; narrower configs zero-extend.
   typedef struct packed {
      logic                is_trap;
      logic [REC_XLEN-1:0] pc;
      logic [REC_INST-1:0] inst;
      logic [REC_XLEN-1:0] wdata;
      logic [REC_XLEN-1:0] mstatus;
      logic                check;
   } sched_rec_t;

   function automatic logic [2:0] slot_count(input logic [MAX_SLOTS-1:0] mask);
      logic [2:0] n;
      n = '0;
      for (int i = 0; i < MAX_SLOTS; i++) n = n + {2'b00, mask[i]};
      return n;
   endfunction

endpackage

// File: rtl/difftest_sched_fifo.sv
// Circular buffer taking up to NW in-order writes per cycle and one read,
// exposing the registered occupancy count.
module difftest_sched_fifo
   import difftest_sched_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int NW    = 3
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic [2:0]                wr_num,
   input  sched_rec_t [NW-1:0]       wr_data,
   input  logic                      rd_en,
   output sched_rec_t                rd_data,
   output logic [$clog2(DEPTH):0]    count
);
   localparam int AW = $clog2(DEPTH);
   typedef logic [AW:0]   cnt_t;
   typedef logic [AW-1:0] ptr_t;

   sched_rec_t mem_q [DEPTH];
   sched_rec_t mem_d [DEPTH];
   ptr_t       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   cnt_t       count_q, count_d;

   always_comb begin
      mem_d = mem_q;
      for (int k = 0; k < NW; k++)
         if (3'(k) < wr_num) mem_d[wr_ptr_q + ptr_t'(k)] = wr_data[k];
      wr_ptr_d = wr_ptr_q + ptr_t'(wr_num);
      rd_ptr_d = rd_ptr_q + ptr_t'(rd_en);
      count_d  = count_q + cnt_t'(wr_num) - cnt_t'(rd_en);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign count   = count_q;

endmodule

// File: rtl/difftest_commit_sched.sv
// Funnels multi-slot commits plus a trap event into an ordered queue drained one
// record per cycle; sequences end of test. Optional counters: DIFFTEST_SCHED_PERF_EN.
module difftest_commit_sched
   import difftest_sched_pkg::*;
#(
   parameter int COMMIT_WIDTH = 2,
   parameter int XLEN         = 64,
   parameter int INST_BITS    = 32,
   parameter int DEPTH        = 16
) (
   input  logic                           clock,
   input  logic                           reset_n,
   input  logic [COMMIT_WIDTH-1:0]        in_valid,
   input  logic [XLEN*COMMIT_WIDTH-1:0]   in_pc,
   input  logic [INST_BITS*COMMIT_WIDTH-1:0] in_inst,
   input  logic [XLEN*COMMIT_WIDTH-1:0]   in_wdata,
   input  logic [XLEN*COMMIT_WIDTH-1:0]   in_mstatus,
   input  logic [COMMIT_WIDTH-1:0]        in_check,
   input  logic                           int_xcpt,
   input  logic [XLEN-1:0]                cause,
   output logic                           in_ready,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           out_is_trap,
   output logic [XLEN-1:0]                out_pc,
   output logic [INST_BITS-1:0]           out_inst,
   output logic [XLEN-1:0]                out_wdata,
   output logic [XLEN-1:0]                out_mstatus,
   output logic                           out_check,
   input  logic                           finish_req,
   output logic                           done,
   output logic                           overflow
`ifdef DIFFTEST_SCHED_PERF_EN
   ,
   output logic [31:0]                    stall_cycles,
   output logic [$clog2(DEPTH):0]         max_occupancy
`endif
);
   localparam int NW = COMMIT_WIDTH + 1;
   localparam int AW = $clog2(DEPTH);
   typedef logic [AW:0] cnt_t;

   sched_state_e         state_q, state_d;
   logic                 done_q, done_d, ovf_q, ovf_d;
   cnt_t                 count;
   sched_rec_t           head;
   sched_rec_t [NW-1:0]  wr_data;
   logic [2:0]           wr_num;
   logic [MAX_SLOTS-1:0] vmask;
   logic                 events, accept, ovf_evt, pop, drained;

   assign vmask    = MAX_SLOTS'(in_valid);
   assign in_ready = (cnt_t'(DEPTH) - count) >= cnt_t'(NW);
   assign accept   = in_ready && (state_q == ST_RUN);
   assign events   = (|in_valid) | int_xcpt;
   assign ovf_evt  = events && !accept;
   assign wr_num   = accept ? slot_count(vmask) + {2'b00, int_xcpt} : 3'd0;
   assign out_valid = (count != '0);
   assign pop      = out_valid && out_ready;
   assign drained  = (count == '0) || (count == cnt_t'(1) && pop);

   // Each write lane k takes the slot whose rank among valid slots is k; the trap
   // lands right after the last valid commit.
   always_comb begin
      wr_data = '0;
      for (int k = 0; k < NW; k++) begin
         for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (in_valid[i] &&
                slot_count(vmask & ((MAX_SLOTS'(1) << i) - MAX_SLOTS'(1))) == 3'(k)) begin
               wr_data[k].is_trap = 1'b0;
               wr_data[k].pc      = REC_XLEN'(in_pc[i*XLEN +: XLEN]);
               wr_data[k].inst    = REC_INST'(in_inst[i*INST_BITS +: INST_BITS]);
               wr_data[k].wdata   = REC_XLEN'(in_wdata[i*XLEN +: XLEN]);
               wr_data[k].mstatus = REC_XLEN'(in_mstatus[i*XLEN +: XLEN]);
               wr_data[k].check   = in_check[i];
            end
         end
         if (int_xcpt && slot_count(vmask) == 3'(k)) begin
            wr_data[k]         = '0;
            wr_data[k].is_trap = 1'b1;
            wr_data[k].wdata   = REC_XLEN'(cause);
         end
      end
   end

   difftest_sched_fifo #(.DEPTH(DEPTH), .NW(NW)) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .wr_num  (wr_num),
      .wr_data (wr_data),
      .rd_en   (pop),
      .rd_data (head),
      .count   (count)
   );

   always_comb begin
      state_d = state_q;
      ovf_d   = ovf_q | ovf_evt;
      case (state_q)
         ST_RUN:   if (ovf_evt) state_d = ST_ERR; else if (finish_req) state_d = ST_DRAIN;
         ST_DRAIN: if (ovf_evt) state_d = ST_ERR; else if (drained)    state_d = ST_DONE;
         default:  state_d = state_q;
      endcase
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_RUN;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
      end
   end

   assign done        = done_q;
   assign overflow    = ovf_q;
   assign out_is_trap = out_valid && head.is_trap;
   assign out_pc      = out_valid ? head.pc[XLEN-1:0]           : '0;
   assign out_inst    = out_valid ? head.inst[INST_BITS-1:0]    : '0;
   assign out_wdata   = out_valid ? head.wdata[XLEN-1:0]        : '0;
   assign out_mstatus = out_valid ? head.mstatus[XLEN-1:0]      : '0;
   assign out_check   = out_valid && head.check;

`ifdef DIFFTEST_SCHED_PERF_EN
   logic [31:0] stall_q, stall_d;
   cnt_t        maxocc_q, maxocc_d;

   always_comb begin
      stall_d = stall_q;
      if (out_valid && !out_ready && stall_q != '1) stall_d = stall_q + 32'd1;
      maxocc_d = (count > maxocc_q) ? count : maxocc_q;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_q  <= '0;
         maxocc_q <= '0;
      end else begin
         stall_q  <= stall_d;
         maxocc_q <= maxocc_d;
      end
   end

   assign stall_cycles  = stall_q;
   assign max_occupancy = maxocc_q;
`endif

endmodule

// File: tb/tb_difftest_commit_sched.sv
// Directed bench for difftest_commit_sched: queue-based reference model compared
// every cycle, plus literal expectations on the key scenarios.
module tb_difftest_commit_sched;
   localparam int CW = 2;
   localparam int DEPTH = 16;
   localparam int M_RUN = 0, M_DRAIN = 1, M_DONE = 2, M_ERR = 3;

   logic           clock, reset_n;
   logic [CW-1:0]  in_valid, in_check;
   logic [127:0]   in_pc, in_wdata, in_mstatus;
   logic [63:0]    in_inst;
   logic           int_xcpt, out_ready, finish_req;
   logic [63:0]    cause;
   logic           in_ready, out_valid, out_is_trap, out_check, done, overflow;
   logic [63:0]    out_pc, out_wdata, out_mstatus;
   logic [31:0]    out_inst;
`ifdef DIFFTEST_SCHED_PERF_EN
   logic [31:0]    stall_cycles;
   logic [4:0]     max_occupancy;
`endif

   difftest_commit_sched dut (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_pc(in_pc),
      .in_inst(in_inst), .in_wdata(in_wdata), .in_mstatus(in_mstatus),
      .in_check(in_check), .int_xcpt(int_xcpt), .cause(cause),
      .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_is_trap(out_is_trap), .out_pc(out_pc), .out_inst(out_inst),
      .out_wdata(out_wdata), .out_mstatus(out_mstatus), .out_check(out_check),
      .finish_req(finish_req), .done(done), .overflow(overflow)
`ifdef DIFFTEST_SCHED_PERF_EN
      , .stall_cycles(stall_cycles), .max_occupancy(max_occupancy)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] inst_of(input logic [63:0] pc);
      return pc[31:0] ^ 32'h0000_0013;
   endfunction
   function automatic logic [63:0] mst_of(input logic [63:0] pc);
      return pc ^ 64'hA5A5_0000_0000_5A5A;
   endfunction

   // Reference model: an ordered list of records plus an abstract mode.
   typedef struct {
      bit          trap;
      logic [63:0] pc;
      logic [31:0] inst;
      logic [63:0] wdata;
      logic [63:0] mst;
      bit          chk;
   } mrec_t;

   mrec_t mq[$];
   int    mmode;
   bit    movf;
   mrec_t mr;
   int    prev_mode;
   bit    mrdy, mev;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mq.delete();
         mmode = M_RUN;
         movf  = 1'b0;
      end else begin
         prev_mode = mmode;
         mrdy = (DEPTH - mq.size()) >= CW + 1;
         mev  = (|in_valid) || int_xcpt;
         if (mq.size() > 0 && out_ready) void'(mq.pop_front());
         if (mev && mrdy && mmode == M_RUN) begin
            for (int i = 0; i < CW; i++) if (in_valid[i]) begin
               mr.trap = 0;
               mr.pc = in_pc[i*64 +: 64];
               mr.inst = in_inst[i*32 +: 32];
               mr.wdata = in_wdata[i*64 +: 64];
               mr.mst = in_mstatus[i*64 +: 64];
               mr.chk = in_check[i];
               mq.push_back(mr);
            end
            if (int_xcpt) begin
               mr.trap = 1; mr.pc = '0; mr.inst = '0; mr.wdata = cause; mr.mst = '0; mr.chk = 0;
               mq.push_back(mr);
            end
         end else if (mev) begin
            movf = 1'b1;
            if (mmode == M_RUN || mmode == M_DRAIN) mmode = M_ERR;
         end
         if (mmode == M_RUN && finish_req) mmode = M_DRAIN;
         if (prev_mode == M_DRAIN && mmode == M_DRAIN && mq.size() == 0) mmode = M_DONE;
      end
   end

   mrec_t hr;
   always @(negedge clock) begin
      if (reset_n) begin
         if (mq.size() > 0) hr = mq[0];
         else begin
            hr.trap = 0; hr.pc = '0; hr.inst = '0; hr.wdata = '0; hr.mst = '0; hr.chk = 0;
         end
         chk("out_valid",   64'(out_valid),   64'(mq.size() > 0));
         chk("in_ready",    64'(in_ready),    64'((DEPTH - mq.size()) >= CW + 1));
         chk("done",        64'(done),        64'(mmode == M_DONE));
         chk("overflow",    64'(overflow),    64'(movf));
         chk("out_is_trap", 64'(out_is_trap), 64'(hr.trap));
         chk("out_pc",      out_pc,           hr.pc);
         chk("out_inst",    64'(out_inst),    64'(hr.inst));
         chk("out_wdata",   out_wdata,        hr.wdata);
         chk("out_mstatus", out_mstatus,      hr.mst);
         chk("out_check",   64'(out_check),   64'(hr.chk));
      end
   end

   // Drive one cycle of stimulus (called at posedge+2), then advance to the next posedge+2.
   task automatic cyc(input logic [1:0] v, input logic [63:0] p0, input logic [63:0] p1,
                      input logic x, input logic [63:0] c, input logic ordy, input logic fin);
      in_valid   = v;
      in_pc      = {p1, p0};
      in_inst    = {inst_of(p1), inst_of(p0)};
      in_wdata   = {~p1, ~p0};
      in_mstatus = {mst_of(p1), mst_of(p0)};
      in_check   = {p1[2], p0[2]};
      int_xcpt   = x;
      cause      = c;
      out_ready  = ordy;
      finish_req = fin;
      @(posedge clock);
      #2;
   endtask

   task automatic idle(input logic ordy);
      cyc(2'b00, 64'd0, 64'd0, 1'b0, 64'd0, ordy, 1'b0);
   endtask

   task automatic rst_pulse();
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0;
      in_valid = '0; in_check = '0; in_pc = '0; in_inst = '0; in_wdata = '0;
      in_mstatus = '0; int_xcpt = 0; cause = '0; out_ready = 0; finish_req = 0;
      #3;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_pc", out_pc, 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      @(posedge clock); #2;
      reset_n = 1'b1;

      // Slot 1 commit followed by a trap in the same cycle.
      cyc(2'b10, 64'd0, 64'h8000_0004, 1'b1, 64'h8000_0000_0000_0007, 1'b1, 1'b0);
      chk("t1_pc", out_pc, 64'h8000_0004);
      chk("t1_not_trap", 64'(out_is_trap), 64'd0);
      idle(1'b1);
      chk("t1_trap", 64'(out_is_trap), 64'd1);
      chk("t1_cause", out_wdata, 64'h8000_0000_0000_0007);
      chk("t1_trap_pc", out_pc, 64'd0);
      idle(1'b1);
      chk("t1_empty", 64'(out_valid), 64'd0);

      // Two pushes every other cycle with continuous pops: wraps past entry 15.
      rst_pulse();
      for (int k = 0; k < 20; k++) begin
         if (k % 2 == 0) cyc(2'b11, 64'h1000 + 64'(16*k), 64'h1004 + 64'(16*k), 1'b0, 64'd0, 1'b1, 1'b0);
         else idle(1'b1);
      end
      idle(1'b1); idle(1'b1);
      chk("t4_drained", 64'(out_valid), 64'd0);

      // Fill five, finish, drain to done; later commits are not queued.
      rst_pulse();
      cyc(2'b11, 64'h300, 64'h304, 1'b0, 64'd0, 1'b0, 1'b0);
      cyc(2'b11, 64'h308, 64'h30c, 1'b0, 64'd0, 1'b0, 1'b0);
      cyc(2'b01, 64'h310, 64'd0,   1'b0, 64'd0, 1'b0, 1'b0);
      cyc(2'b00, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1);
      chk("t3_head", out_pc, 64'h300);
      for (int j = 0; j < 5; j++) begin
         idle(1'b1);
         if (j == 3) chk("t3_done_early", 64'(done), 64'd0);
      end
      chk("t3_done", 64'(done), 64'd1);
      cyc(2'b11, 64'h400, 64'h404, 1'b0, 64'd0, 1'b1, 1'b0);
      chk("t3_no_push", 64'(out_valid), 64'd0);
      chk("t3_done_held", 64'(done), 64'd1);

      // Fill without popping until in_ready drops, then overflow into ERR.
      rst_pulse();
      for (int k = 1; k <= 10; k++) begin
         cyc(2'b11, 64'h100, 64'h104, 1'b0, 64'd0, 1'b0, 1'b0);
         if (k == 6) chk("t2_ready_12", 64'(in_ready), 64'd1);
         if (k == 7) begin
            chk("t2_ready_14", 64'(in_ready), 64'd0);
            chk("t2_no_ovf", 64'(overflow), 64'd0);
         end
         if (k == 8) chk("t2_ovf", 64'(overflow), 64'd1);
      end
      cyc(2'b00, 64'd0, 64'd0, 1'b0, 64'd0, 1'b1, 1'b1);
      for (int k = 0; k < 14; k++) idle(1'b1);
      chk("t2_err_drained", 64'(out_valid), 64'd0);
      chk("t2_err_no_done", 64'(done), 64'd0);

      // Asynchronous reset with seven entries queued.
      rst_pulse();
      cyc(2'b11, 64'h500, 64'h504, 1'b0, 64'd0, 1'b0, 1'b0);
      cyc(2'b11, 64'h508, 64'h50c, 1'b0, 64'd0, 1'b0, 1'b0);
      cyc(2'b11, 64'h510, 64'h514, 1'b0, 64'd0, 1'b0, 1'b0);
      cyc(2'b01, 64'h518, 64'd0,   1'b0, 64'd0, 1'b0, 1'b0);
      chk("t5_queued", 64'(out_valid), 64'd1);
      #1 reset_n = 1'b0;
      #1;
      chk("t5_valid", 64'(out_valid), 64'd0);
      chk("t5_ready", 64'(in_ready), 64'd1);
      chk("t5_done", 64'(done), 64'd0);
      chk("t5_ovf", 64'(overflow), 64'd0);
      chk("t5_pc", out_pc, 64'd0);
      @(posedge clock); #2;
      reset_n = 1'b1;
      cyc(2'b01, 64'h600, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);
      chk("t5_post_valid", 64'(out_valid), 64'd1);
      chk("t5_post_pc", out_pc, 64'h600);

`ifdef DIFFTEST_SCHED_PERF_EN
      rst_pulse();
      cyc(2'b11, 64'h700, 64'h704, 1'b0, 64'd0, 1'b0, 1'b0);
      for (int k = 0; k < 6; k++) idle(1'b0);
      chk("perf_stall", 64'(stall_cycles), 64'd6);
      chk("perf_maxocc", 64'(max_occupancy), 64'd2);
      idle(1'b1); idle(1'b1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
